fp_normalizer_seq: RTL and testbench
====================================

// Module: fp_normalizer_seq
// PURPOSE
// - Post-add normalizer. It is the counterpart of fp_alignment: alignment shifts the smaller operand right to the
//   bigger exponent, and this block brings the raw adder sum back to IEEE-754 single form (fp_pkg::float).
// - Sits between the mantissa adder and the result register.
// - Iterative: one left shift per clock. Valid/ready on both sides.
// PARAMETERS
// - EXP_W   8   exponent field width
// - FRAC_W  23  fraction field width; raw mantissa is FRAC_W+2 bits (carry, hidden, fraction)
// PORTS
// - clk        in   1         clock, rising edge
// - reset      in   1         synchronous, active-high
// - in_valid   in   1         raw sum present
// - in_ready   out  1         block can accept (state==IDLE)
// - in_sign    in   1         sign of sum
// - in_exp     in   EXP_W     exponent of the aligned (bigger) operand
// - in_mant    in   FRAC_W+2  raw sum: [24] carry, [23] hidden, [22:0] fraction
// - out_valid  out  1         result held valid
// - out_ready  in   1         consumer accepts
// - out_fp     out  float     normalized result {sign, exp, frac}
// - out_ovf    out  1         result forced to infinity
// - out_unf    out  1         result is denormal (exp field 0, mant != 0)
// - out_zero   out  1         mantissa was zero
// BEHAVIOUR
// - Reset: state IDLE, out_valid=0, out_fp=0, all flags 0, internal regs 0.
// - in_ready is 1 one cycle after reset.
// - FSM states and transitions:
//   - IDLE: in_ready=1. On in_valid&&in_ready, capture sign/exp/mant and go to EVAL.
//   - EVAL, evaluated in priority order:
//     - in_exp==255: pass through unchanged, go to DONE.
//     - mant==0: exp=0, frac=0, sign kept, zero=1, go to DONE.
//     - mant[24]: mant>>=1, exp+=1. If the new exp==255, frac=0 and ovf=1. Go to DONE.
//     - mant[23]: already normalized, go to DONE.
//     - exp<=1: exp=0, unf=1, go to DONE.
//     - Otherwise go to SHIFT.
//   - SHIFT, each cycle: mant<<=1, exp-=1.
//     - New mant[23]==1: go to DONE.
//     - Else if new exp==1: exp=0, unf=1, go to DONE.
//     - Else stay in SHIFT.
//   - DONE: out_valid=1. out_fp and flags stable while out_ready=0. On out_ready, go to IDLE and out_valid=0 next cycle.
// - Latency: out_valid rises 2 cycles after the accept edge, plus N cycles for N left shifts. N is at most FRAC_W.
// - Throughput: one operation in flight. in_ready=0 in EVAL, SHIFT and DONE; new input is only accepted after DONE drains.
// - Right shift truncates: the lost bit is dropped, unless the rounding option below is compiled in.
// - exp arithmetic uses EXP_W+1 bits internally, so wrap-around is impossible.
// - Flags are mutually exclusive and clear when a new input is accepted.
// - Reset mid-operation: the in-flight result is discarded and no out_valid pulse is produced.
// CONFIGURATION
// - FP_NORM_ROUND_EN defined: on the carry right shift, the lost bit is the guard bit (sticky=0).
//   - Tie rounds to even: if guard=1 and the new LSB=1, mant+=1.
//   - If the increment overflows to bit24, renormalize once more, exp+=1, with the same ovf rule.
//   - Adds 0 cycles.
// - FP_NORM_ROUND_EN undefined: pure truncation. No rounding logic is synthesized.
// TESTING
// - Carry: exp=0x7F, mant=0x1000000 -> out_fp=0x40000000 (2.0). out_valid at accept+2.
// - Cancel: exp=0x81, mant=0x0200000 -> 2 shifts, out_fp=0x3F800000 (1.0). out_valid at accept+4.
// - Zero: sign=1, exp=0x85, mant=0 -> out_fp=0x80000000, out_zero=1.
// - Overflow: exp=0xFE, mant=0x1000000 -> out_fp=0x7F800000, out_ovf=1.
// - Underflow: exp=0x02, mant=0x0200000 -> out_fp=0x00400000, out_unf=1.
// - Backpressure: out_ready=0 for 3 cycles after out_valid.
//   - out_fp stable, in_ready=0, and a new in_valid is not accepted.
//   - Release out_ready: in_ready=1 the next cycle.
// - Rounding: exp=0x7F, mant=0x1000003.
//   - Without FP_NORM_ROUND_EN: frac=0x000001.
//   - With FP_NORM_ROUND_EN: frac=0x000002.
//   - Pulse reset during SHIFT: out_valid stays 0.

Source files
------------

// File: rtl/fp_normalizer_seq.sv
// Iterative post-add normalizer: shifts the raw adder sum left one bit per clock back to IEEE-754 single form.
// Optional tie-to-even rounding on the carry right shift is enabled by defining FP_NORM_ROUND_EN.
package fp_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } float;
endpackage

module fp_normalizer_seq #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [FRAC_W+1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output fp_pkg::float      out_fp,
  output logic              out_ovf,
  output logic              out_unf,
  output logic              out_zero
);

  localparam int MW = FRAC_W + 2;
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W:0] EXP_TWO = {{(EXP_W-1){1'b0}}, 2'b10};

  typedef enum logic [1:0] {IDLE, EVAL, SHIFT, DONE} state_t;

  state_t         state_q, state_d;
  logic           sign_q, sign_d;
  logic [EXP_W:0] exp_q, exp_d;
  logic [MW-1:0]  mant_q, mant_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic           zero_q, zero_d;
  logic           out_valid_q, out_valid_d;
  fp_pkg::float   out_fp_q, out_fp_d;
  logic           out_ovf_q, out_ovf_d;
  logic           out_unf_q, out_unf_d;
  logic           out_zero_q, out_zero_d;

  // Carry right shift result (mant_rs, exp_rs) and single left shift step.
  logic [MW-1:0]  mant_rs;
  logic [EXP_W:0] exp_rs;
  logic [MW-1:0]  mant_sh;
  logic [EXP_W:0] exp_sh;

  assign mant_sh = mant_q << 1;
  assign exp_sh  = exp_q - EXP_ONE;

`ifdef FP_NORM_ROUND_EN
  logic [MW-1:0] mant_half;
  logic [MW-1:0] mant_rnd;

  assign mant_half = mant_q >> 1;
  assign mant_rnd  = mant_half + {{(MW-1){1'b0}}, mant_q[0] & mant_half[0]};

  always_comb begin
    if (mant_rnd[MW-1]) begin
      mant_rs = mant_rnd >> 1;
      exp_rs  = exp_q + EXP_TWO;
    end else begin
      mant_rs = mant_rnd;
      exp_rs  = exp_q + EXP_ONE;
    end
  end
`else
  assign mant_rs = mant_q >> 1;
  assign exp_rs  = exp_q + EXP_ONE;
`endif

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    out_fp_d    = out_fp_q;
    out_ovf_d   = out_ovf_q;
    out_unf_d   = out_unf_q;
    out_zero_d  = out_zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d     = in_sign;
          exp_d      = {1'b0, in_exp};
          mant_d     = in_mant;
          ovf_d      = 1'b0;
          unf_d      = 1'b0;
          zero_d     = 1'b0;
          out_ovf_d  = 1'b0;
          out_unf_d  = 1'b0;
          out_zero_d = 1'b0;
          state_d    = EVAL;
        end
      end
      EVAL: begin
        state_d = DONE;
        if (exp_q == EXP_MAX) begin
          state_d = DONE;
        end else if (mant_q == '0) begin
          exp_d  = '0;
          zero_d = 1'b1;
        end else if (mant_q[MW-1]) begin
          if (exp_rs >= EXP_MAX) begin
            exp_d  = EXP_MAX;
            mant_d = {mant_rs[MW-1:FRAC_W], {FRAC_W{1'b0}}};
            ovf_d  = 1'b1;
          end else begin
            exp_d  = exp_rs;
            mant_d = mant_rs;
          end
        end else if (mant_q[FRAC_W]) begin
          state_d = DONE;
        end else if (exp_q <= EXP_ONE) begin
          exp_d = '0;
          unf_d = 1'b1;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        mant_d = mant_sh;
        exp_d  = exp_sh;
        if (mant_sh[FRAC_W]) begin
          state_d = DONE;
        end else if (exp_sh == EXP_ONE) begin
          exp_d   = '0;
          unf_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // First DONE cycle loads the output register; handshake only once it is visible.
        if (!out_valid_q) begin
          out_valid_d   = 1'b1;
          out_fp_d.sign = sign_q;
          out_fp_d.exp  = exp_q[EXP_W-1:0];
          out_fp_d.frac = mant_q[FRAC_W-1:0];
          out_ovf_d     = ovf_q;
          out_unf_d     = unf_q;
          out_zero_d    = zero_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_fp_q    <= '0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      out_fp_q    <= out_fp_d;
      out_ovf_q   <= out_ovf_d;
      out_unf_q   <= out_unf_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_fp    = out_fp_q;
  assign out_ovf   = out_ovf_q;
  assign out_unf   = out_unf_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_fp_normalizer_seq.sv
// Directed bench for fp_normalizer_seq: one task per scenario with hand-computed expected results.
module tb_fp_normalizer_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_fp;
  logic        out_ovf;
  logic        out_unf;
  logic        out_zero;

  int total = 0;
  int bad   = 0;
  int lat;

  fp_normalizer_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fp    (out_fp),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m);
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid; -1 if the bound expires.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 60) begin
      tick();
      cycles++;
    end
    if (!out_valid) cycles = -1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    total++; if (out_fp !== 32'h0) begin bad++; $display("FAIL reset_fp got=%08h want=00000000", out_fp); end
    total++; if ({out_ovf, out_unf, out_zero} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%03b want=000", {out_ovf, out_unf, out_zero}); end
    reset = 1'b0;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    $display("reset: out_valid=%0b out_fp=%08h in_ready=%0b", out_valid, out_fp, in_ready);
  endtask

  task automatic test_carry();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL carry_ready got=%0b want=1", in_ready); end
    send(1'b0, 8'h7F, 25'h1000000);
    wait_valid(lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL carry_latency got=%0d want=2", lat); end
    total++; if (out_fp !== 32'h40000000) begin bad++; $display("FAIL carry_fp got=%08h want=40000000", out_fp); end
    total++; if ({out_ovf, out_unf, out_zero} !== 3'b000) begin bad++; $display("FAIL carry_flags got=%03b want=000", {out_ovf, out_unf, out_zero}); end
    $display("carry: lat=%0d out_fp=%08h", lat, out_fp);
    drain();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL carry_drain got=v%0b/r%0b want=v0/r1", out_valid, in_ready); end
  endtask

  task automatic test_cancel();
    send(1'b0, 8'h81, 25'h0200000);
    wait_valid(lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL cancel_latency got=%0d want=4", lat); end
    total++; if (out_fp !== 32'h3F800000) begin bad++; $display("FAIL cancel_fp got=%08h want=3F800000", out_fp); end
    total++; if ({out_ovf, out_unf, out_zero} !== 3'b000) begin bad++; $display("FAIL cancel_flags got=%03b want=000", {out_ovf, out_unf, out_zero}); end
    $display("cancel: lat=%0d out_fp=%08h", lat, out_fp);
    drain();
  endtask

  task automatic test_zero();
    send(1'b1, 8'h85, 25'h0);
    wait_valid(lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL zero_latency got=%0d want=2", lat); end
    total++; if (out_fp !== 32'h80000000) begin bad++; $display("FAIL zero_fp got=%08h want=80000000", out_fp); end
    total++; if ({out_ovf, out_unf, out_zero} !== 3'b001) begin bad++; $display("FAIL zero_flags got=%03b want=001", {out_ovf, out_unf, out_zero}); end
    $display("zero: lat=%0d out_fp=%08h zero=%0b", lat, out_fp, out_zero);
    drain();
  endtask

  task automatic test_overflow();
    send(1'b0, 8'hFE, 25'h1000000);
    wait_valid(lat);
    total++; if (out_fp !== 32'h7F800000) begin bad++; $display("FAIL ovf_fp got=%08h want=7F800000", out_fp); end
    total++; if ({out_ovf, out_unf, out_zero} !== 3'b100) begin bad++; $display("FAIL ovf_flags got=%03b want=100", {out_ovf, out_unf, out_zero}); end
    $display("overflow: lat=%0d out_fp=%08h ovf=%0b", lat, out_fp, out_ovf);
    drain();
  endtask

  task automatic test_underflow();
    send(1'b0, 8'h02, 25'h0200000);
    wait_valid(lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL unf_latency got=%0d want=3", lat); end
    total++; if (out_fp !== 32'h00400000) begin bad++; $display("FAIL unf_fp got=%08h want=00400000", out_fp); end
    total++; if ({out_ovf, out_unf, out_zero} !== 3'b010) begin bad++; $display("FAIL unf_flags got=%03b want=010", {out_ovf, out_unf, out_zero}); end
    $display("underflow: lat=%0d out_fp=%08h unf=%0b", lat, out_fp, out_unf);
    drain();
  endtask

  task automatic test_passthrough();
    send(1'b0, 8'hFF, 25'h0400000);
    wait_valid(lat);
    total++; if (out_fp !== 32'h7FC00000) begin bad++; $display("FAIL pass_fp got=%08h want=7FC00000", out_fp); end
    total++; if ({out_ovf, out_unf, out_zero} !== 3'b000) begin bad++; $display("FAIL pass_flags got=%03b want=000", {out_ovf, out_unf, out_zero}); end
    $display("passthrough: lat=%0d out_fp=%08h", lat, out_fp);
    drain();
  endtask

  task automatic test_backpressure();
    send(1'b0, 8'h80, 25'h0C00000);
    wait_valid(lat);
    total++; if (out_fp !== 32'h40400000) begin bad++; $display("FAIL bp_fp got=%08h want=40400000", out_fp); end
    for (int i = 0; i < 3; i++) begin
      in_sign  = 1'b1;
      in_exp   = 8'h10;
      in_mant  = 25'h1000000;
      in_valid = 1'b1;
      tick();
      total++; if (out_valid !== 1'b1 || out_fp !== 32'h40400000 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d got=v%0b/fp%08h/r%0b want=v1/fp40400000/r0", i, out_valid, out_fp, in_ready);
      end
    end
    in_valid = 1'b0;
    drain();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=v%0b/r%0b want=v0/r1", out_valid, in_ready); end
    for (int i = 0; i < 4; i++) tick();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_no_accept got=v%0b/r%0b want=v0/r1", out_valid, in_ready); end
    $display("backpressure: out_fp=%08h in_ready=%0b", out_fp, in_ready);
  endtask

  task automatic test_round();
    logic [31:0] want;
`ifdef FP_NORM_ROUND_EN
    want = 32'h40000002;
`else
    want = 32'h40000001;
`endif
    send(1'b0, 8'h7F, 25'h1000003);
    wait_valid(lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL round_latency got=%0d want=2", lat); end
    total++; if (out_fp !== want) begin bad++; $display("FAIL round_fp got=%08h want=%08h", out_fp, want); end
    $display("round: lat=%0d out_fp=%08h", lat, out_fp);
    drain();
  endtask

  task automatic test_reset_mid_shift();
    int seen;
    send(1'b0, 8'h81, 25'h0200000);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid === 1'b1) seen++;
      tick();
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midreset_valid got=%0d_cycles want=0", seen); end
    total++; if (in_ready !== 1'b1 || out_fp !== 32'h0) begin bad++; $display("FAIL midreset_state got=r%0b/fp%08h want=r1/fp00000000", in_ready, out_fp); end
    $display("reset_mid_shift: valid_cycles=%0d in_ready=%0b", seen, in_ready);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'h0;
    in_mant   = 25'h0;
    out_ready = 1'b0;
    test_reset();
    test_carry();
    test_cancel();
    test_zero();
    test_overflow();
    test_underflow();
    test_passthrough();
    test_backpressure();
    test_round();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
